chacha_block_engine: RTL
========================

Name: chacha_block_engine

Overview:
- Parametrised ChaCha block-cipher engine: accepts key, nonce, counter and one 512-bit data block over a valid/ready handshake.
- Runs a configurable number of rounds with 1, 2 or 4 quarter-rounds per cycle.
- Applies the RFC 8439 feed-forward addition, then XORs the keystream with the data block.
- Sits between the host-side block buffer and the output stream as the next-generation encryption core. It supports ChaCha8/12/20, area/latency trade-off, back-to-back blocks and output backpressure.

Parameters:
- ROUNDS, 20, total rounds (column + diagonal each count as one). Must be even and at least 2; any other value raises an elaboration $error.
- QR_PER_CYCLE, 4, quarter-rounds evaluated per clock. Legal values are 1, 2, 4; any other value raises an elaboration $error.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  engine can accept a request this cycle.
- key  input  256  key words; key[255:224] is state word 4 and key[31:0] is state word 11.
- nonce  input  96  nonce[95:64] is word 13, nonce[63:32] is word 14, nonce[31:0] is word 15.
- counter  input  32  block counter, state word 12.
- plaintext  input  512  data block.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  consumer accepts ciphertext.
- ciphertext  output  512  plaintext XOR keystream; keystream word 0 sits in [511:480] and word 15 in [31:0].
- out_counter  output  32  counter value used for the block being presented.
- busy  output  1  engine holds an in-flight or unconsumed block.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE.
  - out_valid=0, ciphertext=0, out_counter=0, busy=0, round-group counter=0.
  - Working and initial state arrays are cleared.
  - A request presented while reset is low is never accepted.
  - Reset asserted mid-operation discards the in-flight block; no out_valid is produced for it.
- Constants: words 0..3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
- N = ROUNDS*4/QR_PER_CYCLE round cycles per block; for example 20 at (20,4) and 80 at (20,1).
- FSM states:
  - IDLE: in_ready=1.
  - ROUND: in_ready=0; busy=1.
  - OUT: out_valid=1; busy=1; in_ready=out_ready.
- Accept occurs at a clk edge where in_valid && in_ready:
  - Load the 16-word state into both the working copy and the initial copy.
  - Register plaintext and counter internally.
  - Clear the group counter g; go to ROUND.
  - Inputs may change freely after acceptance.
- ROUND, one edge per group g = 0..N-1:
  - Apply QR_PER_CYCLE quarter-rounds in parallel.
  - Round index r = g*QR_PER_CYCLE/4. Even r uses the column set (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15). Odd r uses the diagonal set (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14).
  - Within a round the quarter-rounds are taken in the listed order, QR_PER_CYCLE at a time.
- Quarter-round: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
  - All additions are mod 2^32; rotates are left rotates.
- At the edge applying group N-1:
  - ciphertext <= plaintext ^ {(work[i]+init[i]) mod 2^32, i=0..15}, where work is the result after this final group.
  - out_counter <= the registered counter; go to OUT.
  - out_valid rises N cycles after the accept edge.
- OUT:
  - ciphertext and out_counter are held stable while out_valid && !out_ready.
  - On an edge with out_ready: if in_valid is also high, the new request is accepted in the same edge and the FSM goes to ROUND; otherwise it goes to IDLE.
  - out_valid is 1 only in OUT.
  - Sustained throughput is one block per N+1 cycles.
- Counter arithmetic is the caller's concern; 0xFFFFFFFF is a legal counter and is used as-is, with no internal increment.

Decomposition:
- Package chacha_pkg holds:
  - The four sigma constants as localparams.
  - typedef logic [31:0] word_t.
  - typedef word_t state_t [16].
  - The column and diagonal index tables as localparam arrays.
  - A function building the initial state from key, nonce and counter.
- Sub-module chacha_quarter_round: purely combinational, four word_t in, four word_t out.
  - The engine instantiates QR_PER_CYCLE copies with muxed operand selection.

Test Plan:
1. RFC 8439 §2.3.2 vector at (20,4):
   - Stimulus: key words 0x03020100,0x07060504,…,0x1f1e1d1c; nonce {0x09000000,0x4a000000,0x00000000}; counter=1; plaintext=0.
   - Required: ciphertext[511:480]=0xe4e7f110, [479:448]=0x15593bd1, [31:0]=0x4e3c50a2; out_valid exactly 20 cycles after accept; out_counter=1.
2. Same vector at QR_PER_CYCLE=1 and =2: identical ciphertext, with latency 80 and 40 cycles respectively.
3. Backpressure: hold out_ready=0 for 10 cycles once out_valid rises. Required: ciphertext, out_counter and out_valid stable; in_ready=0; busy=1; then one out_ready pulse → IDLE.
4. Back-to-back: in_valid held high with counters 1 and 2, out_ready=1. Required: second accept on the same edge the first output is consumed; outputs spaced 21 cycles apart; block 2 word 0 matches the golden model.
5. Reset at round group 10: required out_valid=0 and busy=0 immediately; no output for the aborted block; a fresh request after release completes correctly.
6. ROUNDS=8 and counter=0xFFFFFFFF: required match to the reference model (ChaCha8), latency 8 cycles, out_counter=0xFFFFFFFF.

Source files
------------

// File: rtl/chacha_pkg.sv
// ============================================================================
// Module  : chacha_pkg
// Brief   : Shared types, sigma constants, quarter-round index tables and the
//           initial-state builder for the ChaCha block engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t state_t [16];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_OUT   = 2'd2
    } eng_state_e;

    localparam word_t C_SIGMA0 = 32'h61707865;
    localparam word_t C_SIGMA1 = 32'h3320646e;
    localparam word_t C_SIGMA2 = 32'h79622d32;
    localparam word_t C_SIGMA3 = 32'h6b206574;

    // Operand order per quarter-round is (a, b, c, d).
    localparam logic [3:0] C_COL_IDX [4][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15}
    };

    localparam logic [3:0] C_DIAG_IDX [4][4] = '{
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    function automatic state_t build_state(
        input logic [255:0] key,
        input logic [95:0]  nonce,
        input logic [31:0]  counter
    );
        state_t s;
        s[0] = C_SIGMA0;
        s[1] = C_SIGMA1;
        s[2] = C_SIGMA2;
        s[3] = C_SIGMA3;
        for (int i = 0; i < 8; i++) begin
            s[4 + i] = key[255 - 32*i -: 32];
        end
        s[12] = counter;
        s[13] = nonce[95:64];
        s[14] = nonce[63:32];
        s[15] = nonce[31:0];
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chacha_quarter_round.sv
// ============================================================================
// Module  : chacha_quarter_round
// Brief   : Purely combinational ChaCha quarter-round on four 32-bit words.
// Revision: 1.0
// ============================================================================
`default_nettype none

module chacha_quarter_round
    import chacha_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    input  word_t i_c,
    input  word_t i_d,
    output word_t o_a,
    output word_t o_b,
    output word_t o_c,
    output word_t o_d
);

    word_t w_a1, w_x1, w_d1, w_c1, w_x2, w_b1;
    word_t w_a2, w_x3, w_d2, w_c2, w_x4, w_b2;

    assign w_a1 = i_a + i_b;
    assign w_x1 = i_d ^ w_a1;
    assign w_d1 = {w_x1[15:0], w_x1[31:16]};
    assign w_c1 = i_c + w_d1;
    assign w_x2 = i_b ^ w_c1;
    assign w_b1 = {w_x2[19:0], w_x2[31:20]};

    assign w_a2 = w_a1 + w_b1;
    assign w_x3 = w_d1 ^ w_a2;
    assign w_d2 = {w_x3[23:0], w_x3[31:24]};
    assign w_c2 = w_c1 + w_d2;
    assign w_x4 = w_b1 ^ w_c2;
    assign w_b2 = {w_x4[24:0], w_x4[31:25]};

    assign o_a = w_a2;
    assign o_b = w_b2;
    assign o_c = w_c2;
    assign o_d = w_d2;

endmodule

`default_nettype wire

// File: rtl/chacha_block_engine.sv
// ============================================================================
// Module  : chacha_block_engine
// Brief   : Iterative ChaCha block engine with feed-forward and plaintext XOR,
//           valid/ready on both sides, 1/2/4 quarter-rounds per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module chacha_block_engine
    import chacha_pkg::*;
#(
    parameter int ROUNDS       = 20,
    parameter int QR_PER_CYCLE = 4
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    input  logic [511:0] plaintext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] ciphertext,
    output logic [31:0]  out_counter,
    output logic         busy
);

    localparam int N_GROUPS = ROUNDS * 4 / QR_PER_CYCLE;
    localparam int GPR      = 4 / QR_PER_CYCLE;
    localparam int GW       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam logic [GW-1:0] C_G_LAST = GW'(N_GROUPS - 1);

    if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
        $error("chacha_block_engine: ROUNDS must be even and >= 2");
    end
    if ((QR_PER_CYCLE != 1) && (QR_PER_CYCLE != 2) && (QR_PER_CYCLE != 4)) begin : g_bad_qr
        $error("chacha_block_engine: QR_PER_CYCLE must be 1, 2 or 4");
    end

    eng_state_e   r_state;
    eng_state_e   w_state_nxt;
    logic         w_accept;
    logic         w_last;

    state_t       r_work;
    state_t       r_init;
    state_t       w_load;
    state_t       w_work_nxt;
    logic [511:0] r_pt;
    logic [31:0]  r_ctr;
    logic [GW-1:0] r_g;
    logic [511:0] r_ct;
    logic [31:0]  r_out_ctr;
    logic [511:0] w_ct_nxt;

    logic         w_odd;
    logic [3:0]   w_idx [QR_PER_CYCLE][4];
    word_t        w_qi_a [QR_PER_CYCLE];
    word_t        w_qi_b [QR_PER_CYCLE];
    word_t        w_qi_c [QR_PER_CYCLE];
    word_t        w_qi_d [QR_PER_CYCLE];
    word_t        w_qo_a [QR_PER_CYCLE];
    word_t        w_qo_b [QR_PER_CYCLE];
    word_t        w_qo_c [QR_PER_CYCLE];
    word_t        w_qo_d [QR_PER_CYCLE];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                busy = 1'b1;
                if (r_g == C_G_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    // A waiting request is taken on the same edge the block drains.
                    if (in_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_ROUND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Group g belongs to round g/GPR; its quarter-rounds start at slot (g%GPR)*QR.
    always_comb begin
        logic [1:0] slot;
        w_odd = ((int'(r_g) / GPR) % 2) != 0;
        for (int k = 0; k < QR_PER_CYCLE; k++) begin
            slot = 2'((int'(r_g) % GPR) * QR_PER_CYCLE + k);
            for (int j = 0; j < 4; j++) begin
                w_idx[k][j] = w_odd ? C_DIAG_IDX[slot][j] : C_COL_IDX[slot][j];
            end
            w_qi_a[k] = r_work[w_idx[k][0]];
            w_qi_b[k] = r_work[w_idx[k][1]];
            w_qi_c[k] = r_work[w_idx[k][2]];
            w_qi_d[k] = r_work[w_idx[k][3]];
        end
    end

    for (genvar k = 0; k < QR_PER_CYCLE; k++) begin : g_qr
        chacha_quarter_round u_qr (
            .i_a (w_qi_a[k]),
            .i_b (w_qi_b[k]),
            .i_c (w_qi_c[k]),
            .i_d (w_qi_d[k]),
            .o_a (w_qo_a[k]),
            .o_b (w_qo_b[k]),
            .o_c (w_qo_c[k]),
            .o_d (w_qo_d[k])
        );
    end

    always_comb begin
        w_work_nxt = r_work;
        for (int k = 0; k < QR_PER_CYCLE; k++) begin
            w_work_nxt[w_idx[k][0]] = w_qo_a[k];
            w_work_nxt[w_idx[k][1]] = w_qo_b[k];
            w_work_nxt[w_idx[k][2]] = w_qo_c[k];
            w_work_nxt[w_idx[k][3]] = w_qo_d[k];
        end
    end

    always_comb begin
        w_ct_nxt = '0;
        for (int i = 0; i < 16; i++) begin
            w_ct_nxt[511 - 32*i -: 32] = r_pt[511 - 32*i -: 32] ^ (w_work_nxt[i] + r_init[i]);
        end
    end

    always_comb begin
        w_load = build_state(key, nonce, counter);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_work    <= '{default: '0};
            r_init    <= '{default: '0};
            r_pt      <= '0;
            r_ctr     <= '0;
            r_g       <= '0;
            r_ct      <= '0;
            r_out_ctr <= '0;
        end else begin
            if (w_accept) begin
                r_work <= w_load;
                r_init <= w_load;
                r_pt   <= plaintext;
                r_ctr  <= counter;
                r_g    <= '0;
            end else if (r_state == ST_ROUND) begin
                r_work <= w_work_nxt;
                r_g    <= r_g + GW'(1);
            end
            if (w_last) begin
                r_ct      <= w_ct_nxt;
                r_out_ctr <= r_ctr;
            end
        end
    end

    assign ciphertext  = r_ct;
    assign out_counter = r_out_ctr;

endmodule

`default_nettype wire
